// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution: evaluates NVZ branch conditions, redirects
// fetch on taken branches, squashes exactly one fetched instruction, and holds on halt.
module pc_branch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  flag,
    input  logic        flag_busy,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm9,
    input  logic [15:0] reg_target,
    input  logic        halt,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        flush,
    output logic        stall_req,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;

    logic        flag_n, flag_v, flag_z;
    logic        cond_true;
    logic        br_req;
    logic        br_wait;
    logic [15:0] b_offset;
    logic [15:0] target;

    assign flag_n = flag[2];
    assign flag_v = flag[1];
    assign flag_z = flag[0];

    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    assign pc_plus2 = pc_q + 16'd2;
    assign br_req   = branch | branch_reg;
    // The unconditional code never needs flags, so it never waits on EX.
    assign br_wait  = br_req & flag_busy & (ccc != 3'b111);

    // Word offset scaled to bytes: sign-extend then shift left by one.
    assign b_offset = {{6{imm9[8]}}, imm9, 1'b0};
    assign target   = branch_reg ? {reg_target[15:1], 1'b0} : (pc_plus2 + b_offset);

    // Gated by rst so the request is quiet while reset is held.
    assign stall_req = rst & (state_q == ST_RUN) & ~stall & br_wait;

    assign pc_out = pc_q;
    assign flush  = (state_q == ST_FLUSH);
    assign halted = (state_q == ST_HALTED);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (br_wait) begin
                        pc_d = pc_q;
                    end else if (br_req && cond_true) begin
                        pc_d    = target;
                        state_d = ST_FLUSH;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
            end
            ST_FLUSH: begin
                // Decoded controls here belong to the squashed instruction.
                if (!stall) begin
                    pc_d    = pc_plus2;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed vector bench for pc_branch_ctrl: per-cycle stimulus table with
// hand-computed PC/flush/halt results, plus asynchronous reset sequences.
module tb_pc_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  flag;
    logic        flag_busy;
    logic        branch;
    logic        branch_reg;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] reg_target;
    logic        halt;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        flush;
    logic        stall_req;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    pc_branch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flag       (flag),
        .flag_busy  (flag_busy),
        .branch     (branch),
        .branch_reg (branch_reg),
        .ccc        (ccc),
        .imm9       (imm9),
        .reg_target (reg_target),
        .halt       (halt),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .flush      (flush),
        .stall_req  (stall_req),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flag_busy;
        logic [2:0]  flag;
        logic        branch;
        logic        branch_reg;
        logic        halt;
        logic [2:0]  ccc;
        logic [8:0]  imm9;
        logic [15:0] reg_target;
        logic        exp_sreq;
        logic [15:0] exp_pc;
        logic        exp_flush;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic st, input logic fb, input logic [2:0] fl,
                        input logic b, input logic br, input logic h,
                        input logic [2:0] c, input logic [8:0] im, input logic [15:0] rt,
                        input logic esr, input logic [15:0] epc, input logic efl,
                        input logic eh);
        vec_t v;
        v.stall = st; v.flag_busy = fb; v.flag = fl; v.branch = b; v.branch_reg = br;
        v.halt = h; v.ccc = c; v.imm9 = im; v.reg_target = rt;
        v.exp_sreq = esr; v.exp_pc = epc; v.exp_flush = efl; v.exp_halted = eh;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        stall = 0; flag = 3'b000; flag_busy = 0; branch = 0; branch_reg = 0;
        ccc = 3'b000; imm9 = 9'h000; reg_target = 16'h0000; halt = 0;
    endtask

    initial begin
        //   st fb flag  b br h  ccc     imm9    reg_tgt   sreq pc        fl h
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0002, 0, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0004, 0, 0);
        addv(0, 1, 3'b000, 0, 1, 0, 3'b111, 9'h000, 16'h000E, 0, 16'h000E, 1, 0);
        addv(0, 1, 3'b000, 1, 0, 1, 3'b000, 9'h000, 16'h0000, 0, 16'h0010, 0, 0);
        addv(0, 0, 3'b001, 1, 0, 0, 3'b001, 9'h1FE, 16'h0000, 0, 16'h000E, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0010, 0, 0);
        addv(0, 0, 3'b000, 1, 0, 0, 3'b001, 9'h1FE, 16'h0000, 0, 16'h0012, 0, 0);
        addv(0, 1, 3'b000, 1, 0, 0, 3'b011, 9'h010, 16'h0000, 1, 16'h0012, 0, 0);
        addv(0, 1, 3'b000, 1, 0, 0, 3'b011, 9'h010, 16'h0000, 1, 16'h0012, 0, 0);
        addv(0, 0, 3'b100, 1, 0, 0, 3'b011, 9'h010, 16'h0000, 0, 16'h0034, 1, 0);
        addv(1, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0034, 1, 0);
        addv(1, 1, 3'b000, 1, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0034, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0036, 0, 0);
        addv(1, 1, 3'b000, 1, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0036, 0, 0);
        addv(0, 1, 3'b000, 1, 1, 0, 3'b111, 9'h004, 16'h1235, 0, 16'h1234, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h1236, 0, 0);
        addv(0, 0, 3'b000, 1, 0, 0, 3'b010, 9'h002, 16'h0000, 0, 16'h123C, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h123E, 0, 0);
        addv(0, 0, 3'b100, 1, 0, 0, 3'b100, 9'h002, 16'h0000, 0, 16'h1240, 0, 0);
        addv(0, 0, 3'b001, 1, 0, 0, 3'b101, 9'h1FF, 16'h0000, 0, 16'h1240, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h1242, 0, 0);
        addv(0, 0, 3'b010, 0, 1, 0, 3'b110, 9'h000, 16'hFFFC, 0, 16'hFFFC, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'hFFFE, 0, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0000, 0, 0);
        addv(0, 0, 3'b001, 1, 0, 0, 3'b000, 9'h01D, 16'h0000, 0, 16'h0002, 0, 0);
        addv(0, 0, 3'b000, 1, 0, 0, 3'b000, 9'h01D, 16'h0000, 0, 16'h003E, 1, 0);
        addv(0, 0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 0, 16'h0040, 0, 0);
        addv(0, 0, 3'b000, 0, 0, 1, 3'b000, 9'h000, 16'h0000, 0, 16'h0040, 0, 1);
        addv(0, 1, 3'b001, 1, 0, 0, 3'b111, 9'h010, 16'h0000, 0, 16'h0040, 0, 1);
        addv(0, 1, 3'b001, 1, 0, 0, 3'b001, 9'h010, 16'h0000, 0, 16'h0040, 0, 1);
        addv(1, 0, 3'b001, 1, 1, 0, 3'b111, 9'h010, 16'h0100, 0, 16'h0040, 0, 1);
        addv(0, 0, 3'b001, 1, 0, 0, 3'b001, 9'h010, 16'h0000, 0, 16'h0040, 0, 1);
        addv(0, 0, 3'b000, 0, 1, 0, 3'b111, 9'h000, 16'h0200, 0, 16'h0040, 0, 1);

        idle_inputs();
        rst = 1'b0;
        branch = 1; flag_busy = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc_out, 16'h0000);
        check("reset_pc_plus2", pc_plus2, 16'h0002);
        check("reset_flush", {15'd0, flush}, 16'd0);
        check("reset_halted", {15'd0, halted}, 16'd0);
        check("reset_stall_req", {15'd0, stall_req}, 16'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            stall = vecs[i].stall; flag_busy = vecs[i].flag_busy; flag = vecs[i].flag;
            branch = vecs[i].branch; branch_reg = vecs[i].branch_reg; halt = vecs[i].halt;
            ccc = vecs[i].ccc; imm9 = vecs[i].imm9; reg_target = vecs[i].reg_target;
            #1;
            check($sformatf("v%0d_stall_req", i), {15'd0, stall_req}, {15'd0, vecs[i].exp_sreq});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), pc_out, vecs[i].exp_pc);
            check($sformatf("v%0d_pc_plus2", i), pc_plus2, vecs[i].exp_pc + 16'd2);
            check($sformatf("v%0d_flush", i), {15'd0, flush}, {15'd0, vecs[i].exp_flush});
            check($sformatf("v%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].exp_halted});
        end

        // Asynchronous reset out of HALTED, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pc", pc_out, 16'h0000);
        check("async_rst_halted", {15'd0, halted}, 16'd0);

        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        branch_reg = 1; ccc = 3'b111; reg_target = 16'h0100;
        @(posedge clk);
        #1;
        check("pre_rst_pc", pc_out, 16'h0100);
        check("pre_rst_flush", {15'd0, flush}, 16'd1);
        // Reset while a flush is pending must drop it at once.
        #1;
        rst = 1'b0;
        branch_reg = 0; branch = 1; flag_busy = 1; ccc = 3'b000;
        #1;
        check("rst_drop_flush", {15'd0, flush}, 16'd0);
        check("rst_drop_pc", pc_out, 16'h0000);
        check("rst_stall_req", {15'd0, stall_req}, 16'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_pc", pc_out, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Consumer end of the NVZ flag interface: reads the 3-bit flag register output driven by the execution stage and evaluates branch conditions.
- Owns the program counter. Computes the next PC (sequential, PC-relative branch, or register branch) and sequences a one-cycle fetch flush after any taken branch.
- Holds the PC when halted. Sits between decode/EX and instruction fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- stall  input  1  global pipeline stall; freezes PC and state
- flag  input  3  flag register output {N,V,Z}: [2]=N, [1]=V, [0]=Z
- flag_busy  input  1  EX will update flags this cycle; flag value is not yet final
- branch  input  1  decoded B instruction (PC-relative)
- branch_reg  input  1  decoded BR instruction (register target)
- ccc  input  3  branch condition code
- imm9  input  9  signed word offset for B
- reg_target  input  16  target address for BR
- halt  input  1  decoded HLT
- pc_out  output  16  current PC to fetch
- pc_plus2  output  16  pc_out+2, combinational, mod 2^16
- flush  output  1  squash the instruction in fetch/decode
- stall_req  output  1  branch waiting on flags, combinational
- halted  output  1  processor halted

Behaviour:
- Reset (rst=0, async): pc_out=RESET_PC; flush=0; halted=0; state=RUN. stall_req is combinational and 0 while in reset.
- Reset mid-operation: all state is dropped immediately, including any pending flush.
- Condition true per ccc:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 and N=0
  - 011: N=1
  - 100: Z=1 or (Z=0 and N=0)
  - 101: N=1 or Z=1
  - 110: V=1
  - 111: always
- Flags are sampled from `flag` at the same clock edge that commits the decision.
- Targets:
  - B: pc_plus2 + (sext16(imm9) << 1), truncated to 16 bits (wraps).
  - BR: reg_target, with bit0 forced to 0.
- Bus wrap: pc_plus2 of 0xFFFE is 0x0000.
- br_req = branch | branch_reg. If both are asserted, branch_reg wins.
- wait = br_req & flag_busy & (ccc != 3'b111).
- stall_req = wait, in RUN only and with stall=0.
- State RUN, stall=0, in priority order:
  - halt=1: PC holds; next state HALTED.
  - wait=1: PC holds; state stays RUN; no flush. The branch re-evaluates the following cycle.
  - br_req=1 and condition true: pc_out <= target; next state FLUSH.
  - otherwise (not taken, or no branch): pc_out <= pc_plus2.
- State FLUSH:
  - flush=1 (registered; asserted exactly one active cycle after a taken branch).
  - branch, branch_reg and halt are ignored, since they belong to the squashed instruction.
  - pc_out <= pc_plus2; next state RUN.
- State HALTED:
  - halted=1; pc_out holds; all inputs ignored; exits only via reset.
  - flush=0; stall_req=0.
- stall=1 in RUN or FLUSH: pc_out and state hold. In FLUSH, flush stays 1 until the first non-stalled cycle completes. stall_req=0 while stall=1.
- Outputs flush and halted are decoded from the state register.
- Latency: a taken branch redirects pc_out at the next edge. Exactly one instruction is flushed.

Test Plan:
- Reset then run: release rst with stall=0 and no branches -> pc_out sequence 0x0000, 0x0002, 0x0004; flush=0; halted=0.
- Taken B: pc_out=0x0010, branch=1, ccc=001, flag=001, imm9=9'h1FE (-2) -> next pc_out=0x000E; flush=1 for exactly one cycle; then pc_out=0x0010.
- Not taken: same stimulus but flag=000 -> pc_out=0x0012; flush never asserted.
- Flag wait: branch=1, ccc=011, flag_busy=1 for 2 cycles then 0 with flag=100 -> stall_req=1 for 2 cycles, PC held; then pc_out=target and flush=1.
- BR and unconditional wrap: branch_reg=1, ccc=111, reg_target=0x1235, flag_busy=1 -> no wait; pc_out=0x1234. Separately, pc_out=0xFFFE sequential step -> 0x0000.
- Halt and async reset: halt=1 at pc_out=0x0040 -> halted=1, PC held at 0x0040 for 5 cycles despite branch=1. Drive rst=0 mid-cycle -> pc_out=0x0000 and halted=0 immediately, with no clock edge.
